// File: rtl/mnist_mac_pkg.sv
// Shared types, default sizing and the saturating-add helper for the MNIST MAC array.
// PROD_W/CH_W describe the default configuration; parametrised modules derive their own.
package mnist_mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_CH   = 4;
  localparam int DEF_LEN    = 16;
  localparam int DEF_ACC_W  = 20;
  localparam int PROD_W     = 2*DEF_DATA_W+1;
  localparam int CH_W       = $clog2(DEF_N_CH);

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_e;

  typedef struct packed {
    logic signed [63:0] sum;
    logic               sat;
  } sat_res_t;

  // Clamp a+b into the signed range of an acc_w-bit accumulator.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int acc_w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t r;
    s  = a + b;
    hi = (64'sd1 <<< (acc_w-1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sum = s;
    r.sat = 1'b0;
    if (s > hi) begin
      r.sum = hi;
      r.sat = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mnist_mac_array_if.sv
// Pixel/weight beat stream: valid/ready handshake carrying one pixel and N_CH weights.
interface mnist_mac_array_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        px;
  logic [N_CH*DATA_W-1:0]   w;

  modport master (output in_valid, px, w, input in_ready);
  modport slave  (input in_valid, px, w, output in_ready);
endinterface

// File: rtl/mnist_mac_lane.sv
// One class channel: unsigned pixel x signed weight, accumulated with sync clear.
// MNIST_MAC_SAT_EN selects saturating accumulation and exposes a per-beat clamp strobe.
module mnist_mac_lane
  import mnist_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic [DATA_W-1:0]        px_i,
  input  logic signed [DATA_W-1:0] w_i,
  output logic signed [ACC_W-1:0]  acc_o
`ifdef MNIST_MAC_SAT_EN
  ,
  output logic                     sat_o
`endif
);
  localparam int PW = 2*DATA_W+1;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Zero-extended pixel makes the product a plain signed multiply.
  assign prod   = PW'($signed({1'b0, px_i})) * PW'(w_i);
  assign prod_x = ACC_W'(prod);

`ifdef MNIST_MAC_SAT_EN
  sat_res_t res;
  always_comb res = sat_add(64'(acc_q), 64'(prod_x), ACC_W);
  assign sum   = res.sum[ACC_W-1:0];
  assign sat_o = en_i & res.sat;
`else
  assign sum = acc_q + prod_x;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/mnist_mac_array.sv
// N_CH-channel MAC over LEN beats followed by a sequential argmax; done pulses N_CH+1 cycles after the last beat.
// MNIST_MAC_SAT_EN: saturating accumulators plus a sticky sat_flag output.
module mnist_mac_array
  import mnist_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH,
  parameter int LEN    = DEF_LEN,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      start,
  mnist_mac_array_if.slave          beat,
  input  logic [$clog2(N_CH)-1:0]   rd_sel,
  output logic signed [ACC_W-1:0]   rd_acc,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N_CH)-1:0]   class_idx,
  output logic signed [ACC_W-1:0]   class_score
`ifdef MNIST_MAC_SAT_EN
  ,
  output logic                      sat_flag
`endif
);
  localparam int SW = $clog2(N_CH);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           k_q, k_d;
  logic [SW-1:0]           best_idx_q, best_idx_d;
  logic [SW-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0] best_q, best_d;
  logic signed [ACC_W-1:0] score_q, score_d;
  logic signed [ACC_W-1:0] acc [N_CH];
  logic                    fire, clr;

  assign beat.in_ready = (state_q == ACCUM) && ena;
  assign fire          = beat.in_valid && beat.in_ready;
  assign clr           = (state_q == IDLE) && start && ena;

`ifdef MNIST_MAC_SAT_EN
  logic [N_CH-1:0] lane_sat;
  logic            sat_q, sat_d;
  assign sat_d    = clr ? 1'b0 : (sat_q | (|lane_sat));
  assign sat_flag = sat_q;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    mnist_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .en_i  (fire),
      .px_i  (beat.px),
      .w_i   (beat.w[g*DATA_W +: DATA_W]),
      .acc_o (acc[g])
`ifdef MNIST_MAC_SAT_EN
      ,
      .sat_o (lane_sat[g])
`endif
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
    score_d    = score_q;
    if (ena) begin
      case (state_q)
        IDLE: if (start) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
        ACCUM: if (fire) begin
          if (cnt_q == CW'(LEN-1)) begin
            cnt_d   = '0;
            k_d     = '0;
            state_d = ARGMAX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ARGMAX: begin
          // Strict compare keeps the lowest index on ties.
          if (k_q == '0 || acc[k_q] > best_q) begin
            best_d     = acc[k_q];
            best_idx_d = k_q;
          end
          if (k_q == SW'(N_CH-1)) begin
            idx_d   = best_idx_d;
            score_d = best_d;
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + SW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      score_q    <= '0;
`ifdef MNIST_MAC_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
`ifdef MNIST_MAC_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign rd_acc      = acc[rd_sel];
  assign busy        = (state_q == ACCUM) || (state_q == ARGMAX);
  assign done        = (state_q == DONE) && ena;
  assign class_idx   = idx_q;
  assign class_score = score_q;
endmodule

// File: tb/tb_mnist_mac_array.sv
// Directed bench: default-size array (ACC_W=20) plus a narrow ACC_W=17 instance for overflow.
module tb_mnist_mac_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                ena_a, start_a, ena_b, start_b;
  logic [1:0]          rd_sel_a, rd_sel_b;
  logic signed [19:0]  rd_acc_a, score_a;
  logic signed [16:0]  rd_acc_b, score_b;
  logic                busy_a, done_a, busy_b, done_b;
  logic [1:0]          idx_a, idx_b;
`ifdef MNIST_MAC_SAT_EN
  logic                sat_a, sat_b;
`endif

  mnist_mac_array_if #(.DATA_W(8), .N_CH(4)) a_if ();
  mnist_mac_array_if #(.DATA_W(8), .N_CH(4)) b_if ();

  mnist_mac_array #(.DATA_W(8), .N_CH(4), .LEN(16), .ACC_W(20)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .start(start_a), .beat(a_if),
    .rd_sel(rd_sel_a), .rd_acc(rd_acc_a), .busy(busy_a), .done(done_a),
    .class_idx(idx_a), .class_score(score_a)
`ifdef MNIST_MAC_SAT_EN
    , .sat_flag(sat_a)
`endif
  );

  mnist_mac_array #(.DATA_W(8), .N_CH(4), .LEN(16), .ACC_W(17)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .start(start_b), .beat(b_if),
    .rd_sel(rd_sel_b), .rd_acc(rd_acc_b), .busy(busy_b), .done(done_b),
    .class_idx(idx_b), .class_score(score_b)
`ifdef MNIST_MAC_SAT_EN
    , .sat_flag(sat_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_a_pulse();
    @(posedge clk); #1;
    start_a       = 1'b1;
    a_if.in_valid = 1'b1;
    @(negedge clk);
    check_eq("start_cycle_in_ready", a_if.in_ready, 0);
  endtask

  // gap_pct: chance of an idle beat; pause_at: cycle where ena drops for 3 cycles; start_at: stray start.
  task automatic feed_a(input logic [7:0] p, input logic [31:0] wv, input int nbeats,
                        input int gap_pct, input int pause_at, input int start_at);
    int sent = 0;
    int cyc  = 0;
    a_if.px = p;
    a_if.w  = wv;
    while (sent < nbeats && cyc < 400) begin
      @(posedge clk); #1;
      a_if.in_valid = ($urandom_range(0, 99) >= gap_pct);
      ena_a   = !(pause_at >= 0 && cyc >= pause_at && cyc < pause_at + 3);
      start_a = (cyc == start_at);
      @(negedge clk);
      if (!ena_a) check_eq("in_ready_ena_low", a_if.in_ready, 0);
      if (a_if.in_valid && a_if.in_ready) sent++;
      cyc++;
    end
    if (sent < nbeats) check_eq("feed_timeout", sent, nbeats);
  endtask

  task automatic wait_done_a(input string tag, input bit argmax_start);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 50) begin
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
      ena_a   = 1'b1;
      start_a = argmax_start && (n == 1);
      n++;
      @(negedge clk);
      seen = done_a;
    end
    start_a = 1'b0;
    check_eq({tag, "_done_latency"}, n, 5);
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, done_a, 0);
    check_eq({tag, "_idle_busy"}, busy_a, 0);
  endtask

  task automatic check_res_a(input string tag, input int e_idx, input int e_score,
                             input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check_eq({tag, "_class_idx"}, idx_a, e_idx);
    check_eq({tag, "_class_score"}, score_a, e_score);
    for (int k = 0; k < 4; k++) begin
      rd_sel_a = 2'(k);
      #1;
      check_eq({tag, "_acc"}, rd_acc_a, e[k]);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena_a = 1'b1; start_a = 1'b0; ena_b = 1'b1; start_b = 1'b0;
    rd_sel_a = '0; rd_sel_b = '0;
    a_if.in_valid = 1'b0; a_if.px = '0; a_if.w = '0;
    b_if.in_valid = 1'b0; b_if.px = '0; b_if.w = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_in_ready", a_if.in_ready, 0);
    check_eq("rst_class_idx", idx_a, 0);
    check_eq("rst_class_score", score_a, 0);
    check_eq("rst_acc0", rd_acc_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic: px=1, weights ch0..ch3 = 1,2,3,4
    start_a_pulse();
    feed_a(8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, 16, 0, -1, -1);
    wait_done_a("basic", 1'b0);
    check_res_a("basic", 3, 64, 16, 32, 48, 64);
`ifdef MNIST_MAC_SAT_EN
    check_eq("basic_sat_flag", sat_a, 0);
`endif

    // Signed weights with a ch1/ch2 tie
    start_a_pulse();
    feed_a(8'd255, {8'h80, 8'h05, 8'h05, 8'hFF}, 16, 0, -1, -1);
    wait_done_a("signed", 1'b0);
    check_res_a("signed", 1, 20400, -4080, 20400, 20400, -522240);

    // Random valid gaps and a 3-cycle ena freeze
    start_a_pulse();
    feed_a(8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, 16, 30, 4, -1);
    wait_done_a("bp", 1'b0);
    check_res_a("bp", 3, 64, 16, 32, 48, 64);

    // Stray start pulses in ACCUM and ARGMAX
    start_a_pulse();
    feed_a(8'd255, {8'h80, 8'h05, 8'h05, 8'hFF}, 16, 0, -1, 5);
    wait_done_a("ign_start", 1'b1);
    check_res_a("ign_start", 1, 20400, -4080, 20400, 20400, -522240);

    // Reset in the middle of accumulation
    start_a_pulse();
    feed_a(8'd7, {8'd9, 8'd9, 8'd9, 8'd9}, 5, 0, -1, -1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_in_ready", a_if.in_ready, 0);
    check_eq("midrst_busy", busy_a, 0);
    check_eq("midrst_done", done_a, 0);
    check_res_a("midrst", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    a_if.in_valid = 1'b0;
    start_a_pulse();
    feed_a(8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, 16, 0, -1, -1);
    wait_done_a("post_rst", 1'b0);
    check_res_a("post_rst", 3, 64, 16, 32, 48, 64);

    // Overflow on the ACC_W=17 instance: 16 x (255*127)
    begin
      int sent = 0;
      int cyc  = 0;
      int n    = 0;
      bit seen = 1'b0;
      @(posedge clk); #1;
      start_b = 1'b1;
      b_if.px = 8'd255;
      b_if.w  = {4{8'd127}};
      @(posedge clk); #1;
      start_b = 1'b0;
      b_if.in_valid = 1'b1;
      while (sent < 16 && cyc < 100) begin
        @(negedge clk);
        if (b_if.in_valid && b_if.in_ready) sent++;
        cyc++;
        @(posedge clk); #1;
      end
      b_if.in_valid = 1'b0;
      check_eq("ovf_beats", sent, 16);
      while (!seen && n < 50) begin
        @(negedge clk);
        seen = done_b;
        n++;
        if (!seen) begin @(posedge clk); #1; end
      end
      check_eq("ovf_done_seen", seen, 1);
      check_eq("ovf_class_idx", idx_b, 0);
`ifdef MNIST_MAC_SAT_EN
      check_eq("ovf_acc0", rd_acc_b, 65535);
      check_eq("ovf_class_score", score_b, 65535);
      check_eq("ovf_sat_flag", sat_b, 1);
`else
      check_eq("ovf_acc0", rd_acc_b, -6128);
      check_eq("ovf_class_score", score_b, -6128);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
